rvsteel_spi_target: RTL



---
 rtl/rvsteel_spi_target_if.sv | 20 ++
 rtl/rvsteel_spi_target.sv | 98 +++++++++
 2 files changed

// File: rtl/rvsteel_spi_target_if.sv
// rvsteel_spi_target_if: system IO bus bundle for the SPI target register block
// master drives address/strobes/write data; slave returns read data and acknowledges
interface rvsteel_spi_target_if;
    logic [4:0]  rw_address;
    logic [31:0] read_data;
    logic        read_request;
    logic        read_response;
    logic [7:0]  write_data;
    logic [3:0]  write_strobe;
    logic        write_request;
    logic        write_response;
    modport master (
        output rw_address, read_request, write_data, write_strobe, write_request,
        input  read_data, read_response, write_response
    );
    modport slave (
        input  rw_address, read_request, write_data, write_strobe, write_request,
        output read_data, read_response, write_response
    );
endinterface

// File: rtl/rvsteel_spi_target.sv
// rvsteel_spi_target: SPI target with memory-mapped CPOL/CPHA/TXDATA/RXDATA/STATUS registers
// ports: clock, reset (sync, active-high); bus (IO bus slave); sclk/pico/cs async SPI inputs; poci SPI output
module rvsteel_spi_target (
    input  logic                       clock,
    input  logic                       reset,
    rvsteel_spi_target_if.slave        bus,
    input  logic                       sclk,
    input  logic                       pico,
    input  logic                       cs,
    output logic                       poci
);
    logic [2:0] sclk_s, pico_s, cs_s;
    logic       cpol, cpha, tx_full, rx_valid, overrun;
    logic [7:0] tx_buf, rx_data, rx_shift, tx_shift;
    logic [2:0] bit_count;
    logic       selected, cs_fall, cs_rise, sclk_edge, leading, trailing, sample, shift;
    logic       wr, wr_tx, rx_read, complete, load;
    logic [7:0] rx_next;
    logic [31:0] rd_mux;
    always_comb begin
        selected  = ~cs_s[1];
        cs_fall   = cs_s[2] & ~cs_s[1];
        cs_rise   = ~cs_s[2] & cs_s[1];
        sclk_edge = selected & (sclk_s[2] ^ sclk_s[1]);
        leading   = sclk_edge & (sclk_s[1] != cpol);
        trailing  = sclk_edge & (sclk_s[1] == cpol);
        sample    = cpha ? trailing : leading;
        shift     = cpha ? leading : trailing;
        wr        = bus.write_request & (&bus.write_strobe);
        wr_tx     = wr & (bus.rw_address == 5'h08);
        rx_read   = bus.read_request & (bus.rw_address == 5'h0c);
        complete  = sample & (bit_count == 3'd7);
        // CPHA=0 has no shift edge before the first bit, so the first byte loads at cs fall
        load      = (cs_fall & ~cpha) | (shift & (bit_count == 3'd0));
        // pico_s[2] is the pin level just before the detected sclk edge
        rx_next   = {rx_shift[6:0], pico_s[2]};
        rd_mux    = bus.rw_address == 5'h00 ? {31'b0, cpol} :
                    bus.rw_address == 5'h04 ? {31'b0, cpha} :
                    bus.rw_address == 5'h08 ? {24'b0, tx_buf} :
                    bus.rw_address == 5'h0c ? {24'b0, rx_data} :
                    bus.rw_address == 5'h10 ? {28'b0, selected, overrun, tx_full, rx_valid} :
                    32'hdeadbeef;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_s             <= 3'b000;
            pico_s             <= 3'b000;
            cs_s               <= 3'b111;
            bus.read_response  <= 1'b0;
            bus.write_response <= 1'b0;
            bus.read_data      <= 32'hdeadbeef;
            cpol               <= 1'b0;
            cpha               <= 1'b0;
            tx_buf             <= 8'h00;
            tx_full            <= 1'b0;
            rx_data            <= 8'h00;
            rx_valid           <= 1'b0;
            overrun            <= 1'b0;
            rx_shift           <= 8'h00;
            tx_shift           <= 8'hff;
            bit_count          <= 3'd0;
            poci               <= 1'b1;
        end else begin
            sclk_s             <= {sclk_s[1:0], sclk};
            pico_s             <= {pico_s[1:0], pico};
            cs_s               <= {cs_s[1:0], cs};
            bus.read_response  <= bus.read_request;
            bus.write_response <= bus.write_request;
            bus.read_data      <= bus.read_request ? rd_mux : 32'hdeadbeef;
            if (wr & (bus.rw_address == 5'h00) & ~selected)
                cpol <= bus.write_data[0];
            if (wr & (bus.rw_address == 5'h04) & ~selected)
                cpha <= bus.write_data[0];
            if (wr_tx)
                tx_buf <= bus.write_data;
            tx_full  <= wr_tx | (tx_full & ~load);
            rx_valid <= complete | (rx_valid & ~rx_read);
            overrun  <= (complete & rx_valid & ~rx_read) |
                        (overrun & ~(wr & (bus.rw_address == 5'h10) & bus.write_data[2]));
            if (complete)
                rx_data <= rx_next;
            if (cs_fall | cs_rise) begin
                bit_count <= 3'd0;
                rx_shift  <= 8'h00;
            end else if (sample) begin
                bit_count <= bit_count + 3'd1;
                rx_shift  <= rx_next;
            end
            if (cs_rise)
                tx_shift <= 8'hff;
            else if (load)
                tx_shift <= tx_full ? tx_buf : 8'hff;
            else if (shift)
                tx_shift <= {tx_shift[6:0], 1'b1};
            poci <= selected ? tx_shift[7] : 1'b1;
        end
    end
endmodule
